// File: rtl/wb_arb_pkg.sv
// Shared state encoding and bus/owner widths for the Wishbone round-robin arbiter.
package wb_arb_pkg;
   localparam int WB_ADR_MSB  = 15;
   localparam int WB_DAT_MSB  = 15;
   localparam int MAX_MASTERS = 8;
   localparam int OWNER_W     = 3;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GRANT    = 2'd1,
      HANDOVER = 2'd2
   } arb_state_t;
endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: first eligible requester after last_owner, wrapping modulo N.
// Purely combinational, zero latency; it never stalls and holds no state.
module rr_priority_picker
   import wb_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]       req,
   input  logic [N-1:0]       elig,
   input  logic [OWNER_W-1:0] last_owner,
   output logic               pick_vld,
   output logic [OWNER_W-1:0] pick_idx
);
   logic [MAX_MASTERS-1:0] cand;
   logic [OWNER_W:0]       slot;

   always_comb begin
      cand        = '0;
      cand[N-1:0] = req & elig;
      slot        = '0;
      pick_vld    = 1'b0;
      pick_idx    = '0;
      for (int i = 1; i <= N; i++) begin
         slot = {1'b0, last_owner} + (OWNER_W+1)'(i);
         if (slot >= (OWNER_W+1)'(N))
            slot = slot - (OWNER_W+1)'(N);
         if (!pick_vld && cand[slot[OWNER_W-1:0]]) begin
            pick_vld = 1'b1;
            pick_idx = slot[OWNER_W-1:0];
         end
      end
   end
endmodule

// File: rtl/wb_round_robin_arbiter.sv
// Round-robin Wishbone arbiter: grant 1 cycle after CYC, one HANDOVER cycle between tenures.
// Non-owners are held off with STALL=1; the slave's STALL/ACK reach the owner only.
module wb_round_robin_arbiter
   import wb_arb_pkg::*;
#(
   parameter int          WISHBONE_DATAWIDTH    = WB_DAT_MSB,
   parameter int          WISHBONE_ADDRESSWIDTH = WB_ADR_MSB,
   parameter int          NUM_MASTERS           = 4,
   parameter int unsigned TIMEOUT_CYCLES        = 1023
) (
   input  logic                                               CLK_I,
   input  logic                                               RST_N_I,
   input  logic [NUM_MASTERS-1:0]                             M_CYC_I,
   input  logic [NUM_MASTERS-1:0]                             M_STB_I,
   input  logic [NUM_MASTERS-1:0]                             M_WE_I,
   input  logic [NUM_MASTERS*(WISHBONE_ADDRESSWIDTH+1)-1:0]   M_ADR_I,
   input  logic [NUM_MASTERS*(WISHBONE_DATAWIDTH+1)-1:0]      M_DAT_I,
   output logic [NUM_MASTERS-1:0]                             M_GNT_O,
   output logic [NUM_MASTERS-1:0]                             M_ACK_O,
   output logic [NUM_MASTERS-1:0]                             M_STALL_O,
   output logic [WISHBONE_DATAWIDTH:0]                        M_DAT_O,
   output logic                                               S_CYC_O,
   output logic                                               S_STB_O,
   output logic                                               S_WE_O,
   output logic [WISHBONE_ADDRESSWIDTH:0]                     S_ADR_O,
   output logic [WISHBONE_DATAWIDTH:0]                        S_DAT_O,
   input  logic [WISHBONE_DATAWIDTH:0]                        S_DAT_I,
   input  logic                                               S_ACK_I,
   input  logic                                               S_STALL_I,
   output logic [OWNER_W-1:0]                                 owner_o,
   output logic                                               timeout_o
);
   localparam int AW = WISHBONE_ADDRESSWIDTH + 1;
   localparam int DW = WISHBONE_DATAWIDTH + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 2);

   arb_state_t             state;
   logic [OWNER_W-1:0]     owner;
   logic [OWNER_W-1:0]     last_owner;
   logic [NUM_MASTERS-1:0] gnt_q;
   logic [NUM_MASTERS-1:0] penalty;
   logic [NUM_MASTERS-1:0] own_oh;
   logic [TW-1:0]          tenure;
   logic                   timeout_q;
   logic                   in_grant;
   logic                   owner_cyc;
   logic                   wd_expire;
   logic                   pick_vld;
   logic [OWNER_W-1:0]     pick_idx;

   // Per-master inputs padded to MAX_MASTERS so the owner index selects without width games.
   logic [MAX_MASTERS-1:0] cyc_pad, stb_pad, we_pad;
   logic [AW-1:0]          adr_arr [MAX_MASTERS];
   logic [DW-1:0]          dat_arr [MAX_MASTERS];

   for (genvar g = 0; g < MAX_MASTERS; g++) begin : g_pad
      if (g < NUM_MASTERS) begin : g_real
         assign cyc_pad[g] = M_CYC_I[g];
         assign stb_pad[g] = M_STB_I[g];
         assign we_pad[g]  = M_WE_I[g];
         assign adr_arr[g] = M_ADR_I[AW*g +: AW];
         assign dat_arr[g] = M_DAT_I[DW*g +: DW];
      end else begin : g_zero
         assign cyc_pad[g] = 1'b0;
         assign stb_pad[g] = 1'b0;
         assign we_pad[g]  = 1'b0;
         assign adr_arr[g] = '0;
         assign dat_arr[g] = '0;
      end
   end

   rr_priority_picker #(.N(NUM_MASTERS)) u_picker (
      .req        (M_CYC_I),
      .elig       (~penalty),
      .last_owner (last_owner),
      .pick_vld   (pick_vld),
      .pick_idx   (pick_idx)
   );

   assign in_grant  = (state == GRANT);
   assign owner_cyc = cyc_pad[owner];
   assign own_oh    = NUM_MASTERS'(1) << owner;
   assign wd_expire = (TIMEOUT_CYCLES != 0) && (32'(tenure) + 32'd1 == TIMEOUT_CYCLES);

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= OWNER_W'(NUM_MASTERS - 1);
         gnt_q      <= '0;
         penalty    <= '0;
         tenure     <= '0;
         timeout_q  <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         penalty   <= penalty & M_CYC_I;
         unique case (state)
            IDLE: begin
               if (pick_vld) begin
                  state  <= GRANT;
                  owner  <= pick_idx;
                  gnt_q  <= NUM_MASTERS'(1) << pick_idx;
                  tenure <= '0;
               end
            end
            GRANT: begin
               // A release on the expiry cycle wins: no timeout pulse, no penalty.
               if (!owner_cyc) begin
                  state      <= HANDOVER;
                  gnt_q      <= '0;
                  last_owner <= owner;
               end else if (wd_expire) begin
                  state      <= HANDOVER;
                  gnt_q      <= '0;
                  last_owner <= owner;
                  timeout_q  <= 1'b1;
                  penalty    <= (penalty & M_CYC_I) | own_oh;
               end else begin
                  tenure <= tenure + TW'(1);
               end
            end
            HANDOVER: state <= IDLE;
            default:  state <= IDLE;
         endcase
      end
   end

   assign M_GNT_O   = gnt_q;
   assign M_ACK_O   = (in_grant && S_ACK_I) ? own_oh : '0;
   assign M_STALL_O = in_grant ? (~own_oh | {NUM_MASTERS{S_STALL_I}}) : '1;
   assign M_DAT_O   = S_DAT_I;
   assign S_CYC_O   = in_grant;
   assign S_STB_O   = in_grant && owner_cyc && stb_pad[owner];
   assign S_WE_O    = in_grant && owner_cyc && we_pad[owner];
   assign S_ADR_O   = in_grant ? adr_arr[owner] : '0;
   assign S_DAT_O   = in_grant ? dat_arr[owner] : '0;
   assign owner_o   = owner;
   assign timeout_o = timeout_q;
endmodule

// File: tb/tb_wb_round_robin_arbiter.sv
// Directed bench for wb_round_robin_arbiter with a short watchdog (8 cycles).
module tb_wb_round_robin_arbiter;
   logic        CLK_I = 1'b0;
   logic        RST_N_I = 1'b0;
   logic [3:0]  M_CYC_I, M_STB_I, M_WE_I;
   logic [63:0] M_ADR_I, M_DAT_I;
   logic [3:0]  M_GNT_O, M_ACK_O, M_STALL_O;
   logic [15:0] M_DAT_O, S_ADR_O, S_DAT_O, S_DAT_I;
   logic        S_CYC_O, S_STB_O, S_WE_O, S_ACK_I, S_STALL_I, timeout_o;
   logic [2:0]  owner_o;
   int          checks = 0;
   int          failures = 0;

   always #5 CLK_I = ~CLK_I;

   wb_round_robin_arbiter #(
      .WISHBONE_DATAWIDTH    (15),
      .WISHBONE_ADDRESSWIDTH (15),
      .NUM_MASTERS           (4),
      .TIMEOUT_CYCLES        (8)
   ) dut (
      .CLK_I     (CLK_I),
      .RST_N_I   (RST_N_I),
      .M_CYC_I   (M_CYC_I),
      .M_STB_I   (M_STB_I),
      .M_WE_I    (M_WE_I),
      .M_ADR_I   (M_ADR_I),
      .M_DAT_I   (M_DAT_I),
      .M_GNT_O   (M_GNT_O),
      .M_ACK_O   (M_ACK_O),
      .M_STALL_O (M_STALL_O),
      .M_DAT_O   (M_DAT_O),
      .S_CYC_O   (S_CYC_O),
      .S_STB_O   (S_STB_O),
      .S_WE_O    (S_WE_O),
      .S_ADR_O   (S_ADR_O),
      .S_DAT_O   (S_DAT_O),
      .S_DAT_I   (S_DAT_I),
      .S_ACK_I   (S_ACK_I),
      .S_STALL_I (S_STALL_I),
      .owner_o   (owner_o),
      .timeout_o (timeout_o)
   );

   task automatic tick();
      @(posedge CLK_I);
      #1;
   endtask

   task automatic do_reset();
      @(negedge CLK_I);
      RST_N_I = 1'b0;
      @(negedge CLK_I);
      RST_N_I = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      M_CYC_I = '0; M_STB_I = '0; M_WE_I = '0; M_ADR_I = '0; M_DAT_I = '0;
      S_DAT_I = '0; S_ACK_I = 1'b0; S_STALL_I = 1'b0; RST_N_I = 1'b0;
      repeat (2) @(posedge CLK_I);
      #1;
      checks++; if (M_GNT_O !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", M_GNT_O); end
      checks++; if (M_STALL_O !== 4'b1111) begin failures++; $display("FAIL reset_stall got=%b exp=1111", M_STALL_O); end
      checks++; if (M_ACK_O !== 4'b0000) begin failures++; $display("FAIL reset_ack got=%b exp=0000", M_ACK_O); end
      checks++; if ({S_CYC_O, S_STB_O, S_WE_O, S_ADR_O, S_DAT_O} !== 35'd0) begin failures++; $display("FAIL reset_slave got=%h exp=0", {S_CYC_O, S_STB_O, S_WE_O, S_ADR_O, S_DAT_O}); end
      checks++; if ({owner_o, timeout_o} !== 4'd0) begin failures++; $display("FAIL reset_owner_timeout got=%h exp=0", {owner_o, timeout_o}); end
      @(negedge CLK_I);
      RST_N_I = 1'b1;
      tick();
   endtask

   task automatic test_single();
      M_ADR_I = {16'h0000, 16'h0000, 16'h1111, 16'h400A};
      M_DAT_I = {48'h0, 16'h1234};
      M_STB_I = 4'b0011; M_WE_I = 4'b0001; M_CYC_I = 4'b0001;
      #1;
      checks++; if (M_GNT_O !== 4'b0000) begin failures++; $display("FAIL single_gnt_early got=%b exp=0000", M_GNT_O); end
      tick();
      checks++; if (M_GNT_O !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", M_GNT_O); end
      checks++; if (owner_o !== 3'd0) begin failures++; $display("FAIL single_owner got=%0d exp=0", owner_o); end
      checks++; if ({S_CYC_O, S_STB_O, S_WE_O} !== 3'b111) begin failures++; $display("FAIL single_ctrl got=%b exp=111", {S_CYC_O, S_STB_O, S_WE_O}); end
      checks++; if (S_ADR_O !== 16'h400A) begin failures++; $display("FAIL single_adr got=%h exp=400a", S_ADR_O); end
      checks++; if (S_DAT_O !== 16'h1234) begin failures++; $display("FAIL single_wdat got=%h exp=1234", S_DAT_O); end
      S_ACK_I = 1'b1; S_DAT_I = 16'hBEEF; S_STALL_I = 1'b0;
      #1;
      checks++; if (M_ACK_O !== 4'b0001) begin failures++; $display("FAIL single_ack got=%b exp=0001", M_ACK_O); end
      checks++; if (M_STALL_O !== 4'b1110) begin failures++; $display("FAIL single_stall got=%b exp=1110", M_STALL_O); end
      checks++; if (M_DAT_O !== 16'hBEEF) begin failures++; $display("FAIL single_rdat got=%h exp=beef", M_DAT_O); end
      S_ACK_I = 1'b0;
      M_CYC_I = 4'b0000;
      #1;
      checks++; if (S_STB_O !== 1'b0) begin failures++; $display("FAIL single_stb_after_release got=%b exp=0", S_STB_O); end
      tick();
      checks++; if ({M_GNT_O, S_CYC_O} !== 5'd0) begin failures++; $display("FAIL single_release got=%b exp=00000", {M_GNT_O, S_CYC_O}); end
      S_ACK_I = 1'b1;
      #1;
      checks++; if ({M_ACK_O, S_ADR_O} !== 20'd0) begin failures++; $display("FAIL single_idle_ack_adr got=%h exp=0", {M_ACK_O, S_ADR_O}); end
      S_ACK_I = 1'b0; M_STB_I = '0; M_WE_I = '0;
      tick();
   endtask

   task automatic test_round_robin();
      int         seq [5] = '{0, 1, 2, 3, 0};
      int         gap;
      logic [3:0] exp_gnt;
      do_reset();
      M_CYC_I = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_gnt = 4'(1 << seq[k]);
         gap = 0;
         while (M_GNT_O === 4'b0000 && gap < 10) begin
            tick();
            gap++;
         end
         checks++; if (M_GNT_O !== exp_gnt) begin failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, M_GNT_O, exp_gnt); end
         checks++; if (owner_o !== 3'(seq[k])) begin failures++; $display("FAIL rr_owner[%0d] got=%0d exp=%0d", k, owner_o, seq[k]); end
         checks++; if (gap !== ((k == 0) ? 1 : 2)) begin failures++; $display("FAIL rr_gap[%0d] got=%0d exp=%0d", k, gap, (k == 0) ? 1 : 2); end
         tick();
         tick();
         checks++; if (M_GNT_O !== exp_gnt) begin failures++; $display("FAIL rr_hold[%0d] got=%b exp=%b", k, M_GNT_O, exp_gnt); end
         M_CYC_I[seq[k]] = 1'b0;
         tick();
         M_CYC_I[seq[k]] = 1'b1;
      end
      M_CYC_I = 4'b0000;
      repeat (3) tick();
   endtask

   task automatic test_stall();
      M_CYC_I = 4'b0010;
      tick();
      checks++; if ({M_GNT_O, owner_o} !== {4'b0010, 3'd1}) begin failures++; $display("FAIL stall_grant got=%b/%0d exp=0010/1", M_GNT_O, owner_o); end
      S_STALL_I = 1'b1;
      #1;
      checks++; if (M_STALL_O !== 4'b1111) begin failures++; $display("FAIL stall_hi got=%b exp=1111", M_STALL_O); end
      S_STALL_I = 1'b0;
      #1;
      checks++; if (M_STALL_O !== 4'b1101) begin failures++; $display("FAIL stall_lo got=%b exp=1101", M_STALL_O); end
      M_CYC_I = 4'b0000;
      repeat (2) tick();
   endtask

   task automatic test_watchdog();
      int   cnt;
      logic seen;
      M_CYC_I = 4'b0100;
      tick();
      checks++; if (M_GNT_O !== 4'b0100) begin failures++; $display("FAIL wd_grant2 got=%b exp=0100", M_GNT_O); end
      M_CYC_I[3] = 1'b1;
      cnt = 1;
      while (M_GNT_O[2] === 1'b1 && cnt < 20) begin
         tick();
         if (M_GNT_O[2] === 1'b1) cnt++;
      end
      checks++; if (cnt !== 8) begin failures++; $display("FAIL wd_tenure got=%0d exp=8", cnt); end
      checks++; if (timeout_o !== 1'b1) begin failures++; $display("FAIL wd_pulse got=%b exp=1", timeout_o); end
      tick();
      checks++; if ({timeout_o, M_GNT_O} !== 5'd0) begin failures++; $display("FAIL wd_pulse_end got=%b exp=00000", {timeout_o, M_GNT_O}); end
      tick();
      checks++; if (M_GNT_O !== 4'b1000) begin failures++; $display("FAIL wd_next_owner got=%b exp=1000", M_GNT_O); end
      M_CYC_I[3] = 1'b0;
      tick();
      seen = 1'b0;
      repeat (5) begin
         tick();
         if (M_GNT_O !== 4'b0000) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL wd_penalised_grant got=%b exp=0", seen); end
      M_CYC_I = 4'b0000;
      tick();
      M_CYC_I = 4'b0100;
      tick();
      checks++; if (M_GNT_O !== 4'b0100) begin failures++; $display("FAIL wd_regrant got=%b exp=0100", M_GNT_O); end
   endtask

   // Continues from the re-grant of master 2 left by test_watchdog.
   task automatic test_collision();
      repeat (7) tick();
      checks++; if (M_GNT_O !== 4'b0100) begin failures++; $display("FAIL col_hold got=%b exp=0100", M_GNT_O); end
      M_CYC_I = 4'b0000;
      tick();
      checks++; if ({timeout_o, M_GNT_O} !== 5'd0) begin failures++; $display("FAIL col_no_timeout got=%b exp=00000", {timeout_o, M_GNT_O}); end
      M_CYC_I = 4'b0100;
      tick();
      checks++; if (timeout_o !== 1'b0) begin failures++; $display("FAIL col_no_timeout2 got=%b exp=0", timeout_o); end
      tick();
      checks++; if (M_GNT_O !== 4'b0100) begin failures++; $display("FAIL col_no_penalty got=%b exp=0100", M_GNT_O); end
      M_CYC_I = 4'b0000;
      repeat (3) tick();
   endtask

   task automatic test_reset_mid();
      M_CYC_I = 4'b0001; M_STB_I = 4'b0001;
      tick();
      checks++; if ({M_GNT_O, S_STB_O} !== 5'b00011) begin failures++; $display("FAIL rst_mid_setup got=%b exp=00011", {M_GNT_O, S_STB_O}); end
      #2;
      RST_N_I = 1'b0;
      #1;
      checks++; if ({M_GNT_O, S_CYC_O, S_STB_O} !== 6'd0) begin failures++; $display("FAIL rst_mid_drop got=%b exp=000000", {M_GNT_O, S_CYC_O, S_STB_O}); end
      checks++; if (M_STALL_O !== 4'b1111) begin failures++; $display("FAIL rst_mid_stall got=%b exp=1111", M_STALL_O); end
      M_CYC_I = 4'b1001; M_STB_I = 4'b0000;
      @(negedge CLK_I);
      RST_N_I = 1'b1;
      tick();
      checks++; if (M_GNT_O !== 4'b0001) begin failures++; $display("FAIL rst_prio_m0 got=%b exp=0001", M_GNT_O); end
      M_CYC_I = 4'b1000;
      do_reset();
      checks++; if (M_GNT_O !== 4'b1000) begin failures++; $display("FAIL rst_m3_alone got=%b exp=1000", M_GNT_O); end
      M_CYC_I = 4'b0000;
      repeat (2) tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_watchdog();
      test_collision();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wb_round_robin_arbiter.md
# wb_round_robin_arbiter

Shared-bus arbiter for the 16-bit Wishbone fabric: accepts bus requests (CYC) from up to four masters, such as the clock-divisor register reader and the DSP units, and grants exactly one at a time with round-robin fairness. It multiplexes the owner's address/data/strobe onto the single slave-side bus and routes ACK/STALL back. It is the block that drives every master's GNT input, and it sits between the masters and the address decoder.

## Interface
- WISHBONE_DATAWIDTH, 15, MSB index of data buses (16 bits)
- WISHBONE_ADDRESSWIDTH, 15, MSB index of address buses (16 bits)
- NUM_MASTERS, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 1023, maximum GRANT tenure in cycles; 0 disables the watchdog
- CLK_I  in  1  bus clock
- RST_N_I  in  1  reset; one clock, reset asynchronous active-low
- M_CYC_I  in  NUM_MASTERS  per-master bus request
- M_STB_I, M_WE_I  in  NUM_MASTERS  per-master strobe / write-enable
- M_ADR_I  in  NUM_MASTERS*16  packed addresses, master i at [16i+15:16i]
- M_DAT_I  in  NUM_MASTERS*16  packed write data
- M_GNT_O  out  NUM_MASTERS  one-hot grant
- M_ACK_O  out  NUM_MASTERS  ACK routed to owner only
- M_STALL_O  out  NUM_MASTERS  STALL to owner; forced 1 to others
- M_DAT_O  out  16  read data broadcast (S_DAT_I)
- S_CYC_O, S_STB_O, S_WE_O  out  1  slave-side control
- S_ADR_O, S_DAT_O  out  16  slave-side address / write data
- S_DAT_I  in  16  slave read data
- S_ACK_I, S_STALL_I  in  1  slave ACK / stall
- owner_o  out  3  index of current owner
- timeout_o  out  1  one-cycle pulse on watchdog release

## Operation
- States: IDLE, GRANT, HANDOVER.
- IDLE: if any eligible M_CYC_I is high, pick the first requester searching from last_owner+1 modulo NUM_MASTERS. Register owner and grant, then go to GRANT. Otherwise stay in IDLE.
- GRANT:
  - M_GNT_O[owner]=1.
  - S_CYC_O=1.
  - S_STB_O, S_WE_O, S_ADR_O, S_DAT_O follow the owner's inputs combinationally.
  - M_ACK_O[owner]=S_ACK_I and M_STALL_O[owner]=S_STALL_I.
  - When M_CYC_I[owner] falls, go to HANDOVER and set last_owner to owner.
- HANDOVER: all GNT=0, S_CYC_O=0, S_STB_O=0 for exactly one cycle, then IDLE.
- Watchdog: a tenure counter clears on entry to GRANT and increments each GRANT cycle. At TIMEOUT_CYCLES it pulses timeout_o, goes to HANDOVER, and sets the owner's penalty bit. A penalised master is ineligible until its M_CYC_I goes low, which clears the bit.
- Outside GRANT:
  - S_* outputs are 0.
  - M_ACK_O is 0.
  - M_STALL_O is all ones.
- Non-owners always see STALL=1, ACK=0, GNT=0.
- Owner M_STB_I or M_WE_I activity after its CYC falls is ignored.

## Timing
- Reset (async assert, sync deassert by upstream):
  - state=IDLE, last_owner=NUM_MASTERS-1 (master 0 has first priority).
  - owner_o=0, M_GNT_O=0, M_ACK_O=0, M_STALL_O=all ones.
  - S_* outputs=0, timeout_o=0, penalty bits clear.
- Request-to-grant latency: 1 cycle (CYC sampled high at edge n, GNT high after edge n).
- Release: the owner's CYC low at edge n gives GNT low after edge n. The next grant is asserted after edge n+2 at the earliest, so there is always one HANDOVER cycle.
- Masters that double-check GNT (two consecutive samples) see GNT stable for the whole tenure; GNT never glitches while in GRANT.
- Simultaneous requests: round-robin order only; a newly rising CYC during GRANT waits.
- Owner CYC falling in the same cycle the watchdog expires: treat as a normal release, with no timeout_o and no penalty.
- Reset mid-GRANT drops GNT and S_CYC_O immediately (asynchronously).

## Structure
- Package wb_arb_pkg holds the state enum (IDLE/GRANT/HANDOVER), the bus width constants (16-bit ADR/DAT) and the owner index width.
- Sub-module rr_priority_picker is combinational: it takes the request vector, eligibility mask and last_owner, and returns a valid flag and the next owner index. It is reusable by the DSP job scheduler.

## Test plan
- Single request: after reset, M_CYC_I=4'b0001 → GNT[0] high 1 cycle later; S_ADR_O=0x400A when master 0 drives 0x400A; S_ACK_I routed only to M_ACK_O[0].
- Round-robin: all four CYC held high, each drops CYC 3 cycles after grant → owner sequence 0,1,2,3,0 with exactly one idle HANDOVER cycle between grants.
- Stall isolation: master 1 owns the bus and S_STALL_I=1 → M_STALL_O=4'b1111; S_STALL_I=0 → M_STALL_O=4'b1101.
- Watchdog: TIMEOUT_CYCLES=8, master 2 holds CYC indefinitely → timeout_o pulses after 8 GRANT cycles and master 3 is granted next. Master 2 gets no grant until it drops and re-raises CYC.
- Edge collision: owner CYC falls on the watchdog-expiry cycle → timeout_o stays 0 and no penalty is set.
- Reset mid-transfer: RST_N_I low while master 0 is in GRANT with S_STB_O=1 → S_CYC_O, S_STB_O and GNT are 0 within the same cycle. After release, a request from master 3 is granted ahead of master 0 only if master 0 is not requesting.
